// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: selects a resident program, steps/branches/stalls the PC,
// and reports completion through a four-phase Start/Done handshake.
module fetch_ctrl #(
  parameter int unsigned     PC_W       = 8,
  parameter logic [PC_W-1:0] PROG0_BASE = PC_W'(0),
  parameter logic [PC_W-1:0] PROG1_BASE = PC_W'(28),
  parameter logic [PC_W-1:0] PROG2_BASE = PC_W'(48),
  parameter int unsigned     CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [1:0]        ProgSel,
  input  logic [8:0]        Instr,
  input  logic              BranchEn,
  input  logic              BranchTaken,
  input  logic [PC_W-1:0]   Target,
  input  logic              Stall,
  output logic [PC_W-1:0]   PC,
  output logic              Exec,
  output logic              Done,
  output logic              Busy,
  output logic              Err,
  output logic [CNT_W-1:0]  RetCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic              done_q;
  logic              busy_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PC_W-1:0]   base_c;
  logic              instr_done_c;

  // Program base lookup; ProgSel=3 never reaches the PC.
  always_comb begin
    base_c = PROG0_BASE;
    unique case (ProgSel)
      2'd1:    base_c = PROG1_BASE;
      2'd2:    base_c = PROG2_BASE;
      default: base_c = PROG0_BASE;
    endcase
  end

  assign instr_done_c = (Instr == 9'd0);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            if (ProgSel == 2'd3) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= HALT;
            end else begin
              pc_q    <= base_c;
              cnt_q   <= '0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // Stall freezes everything, including done/branch decode.
          if (!Stall) begin
            if (instr_done_c) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= HALT;
            end else begin
              if (BranchEn && BranchTaken) begin
                pc_q <= Target;
              end else begin
                pc_q <= pc_q + PC_W'(1);
                if (pc_q == {PC_W{1'b1}}) err_q <= 1'b1;
              end
              if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HALT: begin
          // A new run requires Start to drop first.
          if (!Start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Exec   = (state_q == RUN) & ~Stall;
  assign PC     = pc_q;
  assign Done   = done_q;
  assign Busy   = busy_q;
  assign Err    = err_q;
  assign RetCnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, handshake/wrap/reset sequences,
// and randomized traffic checked against a rule-level reference model.
module tb_fetch_ctrl;

  logic        CLK;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  ProgSel;
  logic [8:0]  Instr;
  logic        BranchEn;
  logic        BranchTaken;
  logic [7:0]  Target;
  logic        Stall;
  logic [7:0]  PC;
  logic        Exec;
  logic        Done;
  logic        Busy;
  logic        Err;
  logic [15:0] RetCnt;

  fetch_ctrl dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel),
    .Instr(Instr), .BranchEn(BranchEn), .BranchTaken(BranchTaken),
    .Target(Target), .Stall(Stall), .PC(PC), .Exec(Exec), .Done(Done),
    .Busy(Busy), .Err(Err), .RetCnt(RetCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: 0 idle, 1 running, 2 halted.
  int m_st, m_pc, m_cnt;
  bit m_done, m_busy, m_err;
  int bases[3] = '{0, 28, 48};

  typedef struct {
    bit       start;
    bit [1:0] ps;
    bit [8:0] instr;
    bit       ben;
    bit       btk;
    bit [7:0] tgt;
    bit       stall;
    int       pc;
    bit       done;
    bit       busy;
    bit       err;
    int       cnt;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(bit st, bit [1:0] ps, bit [8:0] ins, bit ben, bit btk,
                              bit [7:0] tgt, bit stl, int pc, bit dn, bit bs, bit er, int cnt);
    vec_t v;
    v.start = st; v.ps = ps; v.instr = ins; v.ben = ben; v.btk = btk; v.tgt = tgt;
    v.stall = stl; v.pc = pc; v.done = dn; v.busy = bs; v.err = er; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_cnt = 0; m_done = 0; m_busy = 0; m_err = 0;
  endtask

  // Next state from the behavioural rules, using the inputs present before the edge.
  task automatic model_update();
    int nst;
    nst = m_st;
    if (m_st == 0) begin
      if (Start) begin
        if (ProgSel == 2'd3) begin
          m_err = 1; m_done = 1; nst = 2;
        end else begin
          m_pc = bases[ProgSel]; m_cnt = 0; m_err = 0; nst = 1;
        end
      end
    end else if (m_st == 1) begin
      if (!Stall) begin
        if (Instr == 9'd0) begin
          m_done = 1; nst = 2;
        end else begin
          if (BranchEn && BranchTaken) m_pc = int'(Target);
          else begin
            if (m_pc == 255) m_err = 1;
            m_pc = (m_pc + 1) % 256;
          end
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
      end
    end else begin
      if (!Start) begin
        m_done = 0; nst = 0;
      end
    end
    m_st = nst;
    m_busy = (m_st == 1);
  endtask

  task automatic check_regs(string tag);
    chk({tag, "_pc"},   int'(PC),     m_pc);
    chk({tag, "_done"}, int'(Done),   int'(m_done));
    chk({tag, "_busy"}, int'(Busy),   int'(m_busy));
    chk({tag, "_err"},  int'(Err),    int'(m_err));
    chk({tag, "_cnt"},  int'(RetCnt), m_cnt);
  endtask

  task automatic set_in(bit st, bit [1:0] ps, bit [8:0] ins, bit ben, bit btk,
                        bit [7:0] tgt, bit stl);
    Start = st; ProgSel = ps; Instr = ins; BranchEn = ben; BranchTaken = btk;
    Target = tgt; Stall = stl;
  endtask

  // Called at a negedge with inputs applied: check Exec, cross the edge, check registers.
  task automatic tick(string tag);
    #1;
    chk({tag, "_exec"}, int'(Exec), int'(m_st == 1 && !Stall));
    model_update();
    @(posedge CLK);
    #1;
    check_regs(tag);
    @(negedge CLK);
  endtask

  initial begin
    model_reset();
    Reset_n = 1'b0;
    set_in(0, 0, 9'd1, 0, 0, 8'd0, 0);

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      set_in(1'($urandom), 2'($urandom), 9'($urandom), 1'($urandom), 1'($urandom),
             8'($urandom), 1'($urandom));
      #1;
      chk("rst_exec", int'(Exec), 0);
      check_regs("rst");
    end
    set_in(0, 0, 9'd1, 0, 0, 8'd0, 0);
    Reset_n = 1'b1;
    tick("rel");

    // Directed vectors: program 0 with branches, stalls, priority, bad select, program 2.
    tbl[0]  = mk(1, 0, 9'd1, 0, 0, 8'd0,  0, 0,  0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 9'd1, 0, 0, 8'd0,  0, 1,  0, 1, 0, 1);
    tbl[2]  = mk(0, 0, 9'd1, 0, 0, 8'd0,  0, 2,  0, 1, 0, 2);
    tbl[3]  = mk(0, 0, 9'd1, 0, 0, 8'd0,  0, 3,  0, 1, 0, 3);
    tbl[4]  = mk(0, 0, 9'd1, 0, 0, 8'd0,  0, 4,  0, 1, 0, 4);
    tbl[5]  = mk(0, 0, 9'd1, 0, 0, 8'd0,  0, 5,  0, 1, 0, 5);
    tbl[6]  = mk(0, 0, 9'd1, 1, 0, 8'd20, 0, 6,  0, 1, 0, 6);
    tbl[7]  = mk(0, 0, 9'd1, 0, 0, 8'd0,  0, 7,  0, 1, 0, 7);
    tbl[8]  = mk(0, 0, 9'd0, 1, 1, 8'd9,  1, 7,  0, 1, 0, 7);
    tbl[9]  = mk(0, 0, 9'd0, 0, 0, 8'd0,  1, 7,  0, 1, 0, 7);
    tbl[10] = mk(0, 0, 9'd1, 1, 1, 8'd3,  1, 7,  0, 1, 0, 7);
    tbl[11] = mk(0, 0, 9'd1, 0, 0, 8'd0,  0, 8,  0, 1, 0, 8);
    tbl[12] = mk(0, 0, 9'd5, 1, 1, 8'd16, 0, 16, 0, 1, 0, 9);
    tbl[13] = mk(0, 0, 9'd7, 1, 1, 8'd2,  0, 2,  0, 1, 0, 10);
    tbl[14] = mk(1, 0, 9'd0, 1, 1, 8'd9,  0, 2,  1, 0, 0, 10);
    tbl[15] = mk(1, 1, 9'd1, 0, 0, 8'd0,  0, 2,  1, 0, 0, 10);
    tbl[16] = mk(0, 0, 9'd1, 0, 0, 8'd0,  0, 2,  0, 0, 0, 10);
    tbl[17] = mk(1, 3, 9'd1, 0, 0, 8'd0,  0, 2,  1, 0, 1, 10);
    tbl[18] = mk(0, 0, 9'd1, 0, 0, 8'd0,  0, 2,  0, 0, 1, 10);
    tbl[19] = mk(1, 2, 9'd1, 0, 0, 8'd0,  0, 48, 0, 1, 0, 0);
    tbl[20] = mk(1, 0, 9'd0, 0, 0, 8'd0,  0, 48, 1, 0, 0, 0);
    tbl[21] = mk(0, 0, 9'd0, 0, 0, 8'd0,  0, 48, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].start, tbl[i].ps, tbl[i].instr, tbl[i].ben, tbl[i].btk,
             tbl[i].tgt, tbl[i].stall);
      tick($sformatf("m%0d", i));
      chk($sformatf("tbl%0d_pc", i),   int'(PC),     tbl[i].pc);
      chk($sformatf("tbl%0d_done", i), int'(Done),   int'(tbl[i].done));
      chk($sformatf("tbl%0d_busy", i), int'(Busy),   int'(tbl[i].busy));
      chk($sformatf("tbl%0d_err", i),  int'(Err),    int'(tbl[i].err));
      chk($sformatf("tbl%0d_cnt", i),  int'(RetCnt), tbl[i].cnt);
    end

    // Program 1 straight-line run; ROM returns 0 only at address 47.
    set_in(1, 1, 9'd1, 0, 0, 8'd0, 0);
    tick("p1s");
    chk("p1_base", int'(PC), 28);
    for (int k = 0; k < 40 && !m_done; k++) begin
      Instr = (PC == 8'd47) ? 9'd0 : 9'd1;
      tick("p1");
      if (!m_done) chk("p1_walk", int'(PC), 29 + k);
    end
    chk("p1_done",   int'(Done),   1);
    chk("p1_pc",     int'(PC),     47);
    chk("p1_retcnt", int'(RetCnt), 19);
    set_in(0, 0, 9'd1, 0, 0, 8'd0, 0);
    tick("p1e");
    chk("p1_idle_done", int'(Done), 0);

    // Program 0 runs off the top of the address space.
    set_in(1, 0, 9'd1, 0, 0, 8'd0, 0);
    tick("w0");
    for (int k = 0; k < 255; k++) tick("w");
    chk("wrap_pre_pc", int'(PC), 255);
    chk("wrap_pre_err", int'(Err), 0);
    tick("w1");
    chk("wrap_pc",   int'(PC),   0);
    chk("wrap_err",  int'(Err),  1);
    chk("wrap_busy", int'(Busy), 1);
    tick("w2");
    chk("wrap_cont_pc", int'(PC), 1);
    Instr = 9'd0;
    tick("w3");
    set_in(0, 0, 9'd1, 0, 0, 8'd0, 0);
    tick("w4");

    // Asynchronous reset between edges while running at PC=40.
    set_in(1, 1, 9'd1, 0, 0, 8'd0, 0);
    tick("r0");
    for (int k = 0; k < 20 && m_pc != 40; k++) tick("r");
    chk("mid_pre_pc", int'(PC), 40);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_exec", int'(Exec), 0);
    check_regs("mid");
    Start = 1'b0;
    @(negedge CLK);
    Reset_n = 1'b1;
    tick("mid_rel");

    // Randomized traffic against the reference model.
    Start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 4) == 0) Start = ~Start;
      ProgSel     = 2'($urandom);
      Instr       = ($urandom_range(0, 19) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      BranchEn    = 1'($urandom);
      BranchTaken = 1'($urandom);
      Target      = 8'($urandom);
      Stall       = ($urandom_range(0, 4) == 0);
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter sequencer that drives the 8-bit PC into the instruction ROM and receives the 9-bit instruction back combinationally in the same cycle.
- Selects one of three resident programs, then steps, branches and stalls the PC.
- Detects the all-zero "done" instruction and reports completion to the test harness through a four-phase Start/Done handshake.
- Sits between the top-level harness, the instruction ROM and the datapath branch/condition logic.

Parameters:
PC_W, 8, PC width; increment wraps modulo 2^PC_W.
PROG0_BASE, 8'd0, start address of program 0 (multiply).
PROG1_BASE, 8'd28, start address of program 1 (string match).
PROG2_BASE, 8'd48, start address of program 2 (closest pair).
CNT_W, 16, width of the retired-instruction counter.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
Reset_n  in  1  asynchronous, active-low reset.
Start  in  1  level request from the harness: run program ProgSel.
ProgSel  in  2  program select, sampled in IDLE when Start=1; 3 is invalid.
Instr  in  9  instruction at the current PC, returned combinationally by the ROM.
BranchEn  in  1  the current instruction is a branch.
BranchTaken  in  1  the datapath condition for the current branch is true.
Target  in  PC_W  absolute branch target.
Stall  in  1  datapath hold; the PC and counter freeze.
PC  out  PC_W  program counter driven to the ROM.
Exec  out  1  Instr is valid and the datapath executes it this cycle.
Done  out  1  completion acknowledge.
Busy  out  1  state is RUN.
Err  out  1  sticky error flag.
RetCnt  out  CNT_W  count of instructions retired in the current run.

Behaviour:
- Reset (Reset_n=0, asynchronous, takes effect immediately with no clock edge needed):
  - state=IDLE, PC=0, Done=0, Busy=0, Err=0, RetCnt=0.
  - Exec is combinational and reads 0 as a consequence.
- States: IDLE, RUN, HALT.
- IDLE:
  - PC holds. Exec=0.
  - Start=1 and ProgSel in {0,1,2}: on the next edge, PC <= PROGn_BASE, RetCnt <= 0, Err <= 0, go to RUN.
  - Start=1 and ProgSel=3: on the next edge, Err <= 1, go to HALT with Done=1, PC unchanged. The harness must still complete the handshake.
- RUN:
  - Busy=1.
  - Exec = (state==RUN) & ~Stall, combinational.
  - Per-edge priority, highest first:
    1. Stall=1: PC, RetCnt and state hold. Branch and done decoding are ignored that cycle.
    2. Instr==9'b0 (done): PC holds, go to HALT, Done <= 1. RetCnt does not count the done instruction. Done wins over a simultaneous BranchEn.
    3. BranchEn & BranchTaken: PC <= Target; RetCnt += 1.
    4. Otherwise: PC <= PC+1; RetCnt += 1.
  - BranchEn with BranchTaken=0 behaves as case 4.
  - Increment from 2^PC_W-1 wraps to 0 and sets Err <= 1 (sticky). Execution continues after the wrap.
  - A branch whose Target equals PC is legal and is not an error.
  - RetCnt saturates at all-ones and does not wrap.
  - Start falling during RUN is ignored; the program runs to completion.
- HALT:
  - Done=1, Busy=0, Exec=0. PC, RetCnt and Err hold for readback.
  - Start=0: go to IDLE on the next edge; Done <= 0.
  - Start held at 1: stay in HALT. A new run never begins without a Start low phase.
- Latency:
  - Start seen high at edge k gives PC=base and Exec=1 (if Stall=0) after edge k.
  - The done instruction at edge m gives Done=1 after edge m.
- Reset asserted mid-RUN or mid-HALT aborts immediately to the reset values. There is no partial Done.
- No combinational path from Instr/BranchEn/Target to PC. Exec depends only on state and Stall.

Test Plan:
- Reset: hold Reset_n=0 with random inputs -> PC=0, Done=0, Busy=0, Err=0, RetCnt=0. Deassert with Start=0 -> PC stays 0 in IDLE.
- Program 1 with no branches: Start=1, ProgSel=1, ROM returns Instr=9'b1 until PC=47, where it returns 0.
  - Required response: PC walks 28,29,...,47 on consecutive edges.
  - Done=1 the edge after PC=47. RetCnt=19. Drop Start -> IDLE, Done=0.
- Branch and stall:
  - At PC=16, BranchEn=1 and BranchTaken=1 with Target=2 -> next PC=2.
  - At PC=5, BranchEn=1 and BranchTaken=0 -> next PC=6.
  - Stall=1 for 3 cycles at PC=7 -> PC stays 7, Exec=0, RetCnt frozen.
- Priority: Instr=0 with BranchEn=1, BranchTaken=1, Target=9 -> HALT, PC holds, Done=1.
- Errors:
  - ProgSel=3 with Start -> Err=1, Done=1, PC unchanged.
  - Run from PROG0_BASE=0 with a ROM returning nonzero at PC=255 -> PC wraps to 0, Err=1, Busy stays 1.
- Reset mid-run: assert Reset_n=0 asynchronously between edges at PC=40 -> immediate PC=0, Busy=0, Done=0.
